regfile_mips_bw: RTL
====================

# regfile_mips_bw

Parametrised MIPS-style register file: `2**ADDR_WIDTH` registers of `DATA_WIDTH` bits. It has two asynchronous read ports (Rs, Rt), one synchronous write port (Rd) with active-low per-byte write enables, and register 0 hardwired to zero. It adds an asynchronous reset and a multi-cycle clear sweep with a busy indication. It sits in the decode stage of the CPU datapath and replaces the fixed 4x4 bit-enable register file.

## Interface
- `DATA_WIDTH`, 32: register width in bits; must be a multiple of 8, minimum 8.
- `ADDR_WIDTH`, 5: register address width; register count is `2**ADDR_WIDTH`; minimum 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Rs_addr` in ADDR_WIDTH: read port A address.
- `Rt_addr` in ADDR_WIDTH: read port B address.
- `Rd_addr` in ADDR_WIDTH: write address.
- `Rd_in` in DATA_WIDTH: write data.
- `Rd_Byte_w_en` in DATA_WIDTH/8: per-byte write enable, active-low; bit k covers `Rd_in[8k+7:8k]`.
- `clr` in 1: start a clear sweep; sampled only in IDLE.
- `busy` out 1: high while a sweep is in progress.
- `Rs_out` out DATA_WIDTH: data at `Rs_addr`.
- `Rt_out` out DATA_WIDTH: data at `Rt_addr`.

## Operation
- Reset (`rst_n`=0): all registers 0, FSM to IDLE, sweep pointer 0, `busy`=0. `Rs_out` and `Rt_out` therefore read 0.
- Write (IDLE only), at a rising edge:
  - Each byte k with `Rd_Byte_w_en[k]`=0 takes `Rd_in` byte k; other bytes are kept.
  - All-ones enable is a no-op.
  - `Rd_addr`=0 is a no-op.
- Read: combinational from the array.
  - Address 0 always returns 0.
  - Rs and Rt are independent; both may address the same register.
- FSM states:
  - IDLE: `busy`=0. `clr`=1 at an edge goes to SWEEP with pointer=1. If a write is also present in that same cycle, it completes normally.
  - SWEEP: `busy`=1. Each edge zeroes `register[pointer]` and increments the pointer. When pointer = `2**ADDR_WIDTH-1` is zeroed, go to IDLE and set pointer to 0.
- In SWEEP:
  - Writes are ignored (dropped); upstream must stall on `busy`.
  - `clr` is ignored.
  - Reads return current array contents: already-swept registers read 0, the rest keep old values.
- Reset mid-sweep: immediate return to IDLE with the array zeroed.

## Timing
- Read latency: 0 cycles, combinational from address.
- Write visibility without bypass: written data appears on `Rs_out`/`Rt_out` after the write edge.
- Sweep timing:
  - `busy` rises the edge after `clr` is sampled.
  - `busy` stays high exactly `2**ADDR_WIDTH-1` cycles and falls on the edge that zeroes the last register.
  - A write presented in the first cycle after `busy` falls is accepted.
- `ADDR_WIDTH`=1: sweep lasts 1 cycle (register 1 only).
- Pointer must not wrap to 0 inside SWEEP.

## Configuration
- `REGFILE_BYPASS_EN`
  - Defined: in IDLE, if `Rs_addr` (or `Rt_addr`) equals a nonzero `Rd_addr` in the same cycle, the read port returns merged data combinationally: enabled bytes from `Rd_in`, disabled bytes from the array. This gives write-to-read forwarding in the same cycle. Bypass is inactive in SWEEP and for address 0.
  - Not defined: reads reflect the array only; new data appears the cycle after the write edge.

## Structure
- Shared package `regfile_pkg`:
  - FSM state typedef (`RF_IDLE`, `RF_SWEEP`).
  - Byte-lane width constant 8.
- Sub-module `regfile_bw_merge`: combinational byte-lane merge (old word, new word, active-low enables → merged word). It is used by the write path and, under `REGFILE_BYPASS_EN`, by each read port's bypass.

## Test plan
- Reset, then read all addresses → every `Rs_out`/`Rt_out` = 0, `busy`=0.
- Write reg 3 with 0xDEADBEEF, enables 4'b0000; next cycle write reg 3 with 0x11223344, enables 4'b1010 → reg 3 reads 0xDE22BE44.
- Write reg 0 with 0xFFFFFFFF, enables 4'b0000 → reg 0 still reads 0; Rs=Rt=0 both read 0.
- Fill regs 1..31 with their index, pulse `clr`:
  - `busy` is high 31 cycles.
  - Mid-sweep, reg 1 reads 0 and reg 31 reads 31.
  - A write to reg 31 during the sweep is dropped.
  - After the sweep all registers read 0.
- Assert `rst_n`=0 at sweep cycle 10 → `busy`=0 immediately, all registers 0; `clr` after release starts a fresh 31-cycle sweep.
- Bypass build: write reg 5 with 0xA5A5A5A5 (enables 4'b0000) while Rs_addr=5 → `Rs_out`=0xA5A5A5A5 in the same cycle. Non-bypass build: old value that cycle, new value the next.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the byte-write MIPS register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Width of one write-enable lane.
  localparam int RF_BYTE_W = 8;

  // Register-file control state: normal operation or clear sweep.
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_t;

  // Number of byte lanes in a word of the given width.
  function automatic int rf_lanes(input int data_width);
    return data_width / RF_BYTE_W;
  endfunction

endpackage

// File: rtl/regfile_bw_merge.sv
// Byte-lane merge: each lane whose active-low enable is 0 takes new_word, else old_word.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module regfile_bw_merge
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           old_word,
  input  logic [DATA_WIDTH-1:0]           new_word,
  input  logic [DATA_WIDTH/RF_BYTE_W-1:0] byte_en_n,
  output logic [DATA_WIDTH-1:0]           merged_word
);

  localparam int LANES = rf_lanes(DATA_WIDTH);

  // Start from the old word and overwrite only the enabled lanes.
  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < LANES; k++) begin
      if (!byte_en_n[k]) begin
        merged_word[k*RF_BYTE_W +: RF_BYTE_W] = new_word[k*RF_BYTE_W +: RF_BYTE_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mips_bw.sv
// MIPS register file: 2 async read ports, 1 byte-enabled write port, r0 = 0, clear sweep.
// Latency: reads 0 cycles; writes visible after the write edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: busy is high during a sweep; writes and clr presented while busy are dropped.
module regfile_mips_bw
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          Rs_addr,
  input  logic [ADDR_WIDTH-1:0]          Rt_addr,
  input  logic [ADDR_WIDTH-1:0]          Rd_addr,
  input  logic [DATA_WIDTH-1:0]          Rd_in,
  input  logic [DATA_WIDTH/RF_BYTE_W-1:0] Rd_Byte_w_en,
  input  logic                           clr,
  output logic                           busy,
  output logic [DATA_WIDTH-1:0]          Rs_out,
  output logic [DATA_WIDTH-1:0]          Rt_out
);

  localparam int                    NREG      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;

  logic [DATA_WIDTH-1:0] regs [NREG];

  rf_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic                  wr_allow;
  logic                  sweep_zero;
  logic                  wr_addr_nz;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rs_arr;
  logic [DATA_WIDTH-1:0] rt_arr;

  // State and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic: clr starts a sweep at r1; the sweep ends on the edge that zeroes the last register.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    busy       = 1'b0;
    wr_allow   = 1'b0;
    sweep_zero = 1'b0;
    case (state)
      RF_IDLE: begin
        wr_allow = 1'b1;
        if (clr) begin
          state_nxt = RF_SWEEP;
          ptr_nxt   = PTR_FIRST;
        end
      end
      RF_SWEEP: begin
        busy       = 1'b1;
        sweep_zero = 1'b1;
        if (ptr == PTR_LAST) begin
          state_nxt = RF_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + PTR_FIRST;
        end
      end
      default: begin
        state_nxt = RF_IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // r0 is never written; an all-ones enable leaves the word unchanged so it is skipped too.
  assign wr_addr_nz = (Rd_addr != '0);
  assign wr_en      = wr_allow && wr_addr_nz && !(&Rd_Byte_w_en);

  regfile_bw_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_merge (
    .old_word    (regs[Rd_addr]),
    .new_word    (Rd_in),
    .byte_en_n   (Rd_Byte_w_en),
    .merged_word (wr_word)
  );

  // Register array: async clear, sweep zeroing in SWEEP, byte-merged writes in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (sweep_zero) begin
      regs[ptr] <= '0;
    end else if (wr_en) begin
      regs[Rd_addr] <= wr_word;
    end
  end

  assign rs_arr = regs[Rs_addr];
  assign rt_arr = regs[Rt_addr];

`ifdef REGFILE_BYPASS_EN
  logic                  rs_hit;
  logic                  rt_hit;
  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;

  // Forward the in-flight write only in IDLE and never for r0.
  assign rs_hit = wr_allow && wr_addr_nz && (Rs_addr == Rd_addr);
  assign rt_hit = wr_allow && wr_addr_nz && (Rt_addr == Rd_addr);

  regfile_bw_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rs_fwd (
    .old_word    (rs_arr),
    .new_word    (Rd_in),
    .byte_en_n   (Rd_Byte_w_en),
    .merged_word (rs_fwd)
  );

  regfile_bw_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rt_fwd (
    .old_word    (rt_arr),
    .new_word    (Rd_in),
    .byte_en_n   (Rd_Byte_w_en),
    .merged_word (rt_fwd)
  );

  // Read port A: r0 reads zero, otherwise forwarded or stored data.
  always_comb begin
    Rs_out = rs_arr;
    if (Rs_addr == '0) begin
      Rs_out = '0;
    end else if (rs_hit) begin
      Rs_out = rs_fwd;
    end
  end

  // Read port B: r0 reads zero, otherwise forwarded or stored data.
  always_comb begin
    Rt_out = rt_arr;
    if (Rt_addr == '0) begin
      Rt_out = '0;
    end else if (rt_hit) begin
      Rt_out = rt_fwd;
    end
  end
`else
  // Read port A: r0 reads zero, otherwise the stored word.
  always_comb begin
    Rs_out = rs_arr;
    if (Rs_addr == '0) begin
      Rs_out = '0;
    end
  end

  // Read port B: r0 reads zero, otherwise the stored word.
  always_comb begin
    Rt_out = rt_arr;
    if (Rt_addr == '0) begin
      Rt_out = '0;
    end
  end
`endif

endmodule
